// File: rtl/bmp_saver.sv
// Streams an RGB444 framebuffer from SDRAM to SD card as an uncompressed 24-bit BMP file.
// Bytes are packed into a 512-byte block buffer; each full block goes out as one single-block write.
module bmp_saver #(
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned START_BLOCK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BMPSave_En,
  output logic        BMPSave_Complite,
  output logic        BMPSave_Fail,
  input  logic        SD_Init_Complite,
  output logic [31:0] SD_Addr_Block,
  output logic        SD_Enable,
  output logic        SD_Write,
  input  logic        SD_Complite,
  input  logic        SD_Fail,
  output logic [31:0] SD_SerialCount,
  input  logic        SD_InPut_Data_Valid,
  input  logic [31:0] SD_InPut_Data_Addr,
  output logic [31:0] SD_InPut_Data,
  output logic        Serial_access_read,
  input  logic        m_ready_read,
  output logic        m_valid_read,
  output logic [23:0] m_addr_read,
  input  logic [15:0] m_out_data
);

  localparam int unsigned ROWLEN    = (IMG_WIDTH * 3 + 3) & ~32'd3;
  localparam int unsigned PAD_BYTES = ROWLEN - IMG_WIDTH * 3;
  localparam int unsigned IMGSIZE   = ROWLEN * IMG_HEIGHT;
  localparam int unsigned FILESIZE  = 54 + IMGSIZE;
  localparam logic [10:0] H_LAST    = 11'(IMG_WIDTH - 1);
  localparam logic [10:0] V_LAST    = 11'(IMG_HEIGHT - 1);
  localparam logic [1:0]  PAD_LAST  = 2'(PAD_BYTES - 1);
  localparam logic [5:0]  HDR_LAST  = 6'd53;
  localparam logic [8:0]  PTR_LAST  = 9'd511;
  localparam logic [4:0]  RETRY_MAX = 5'd31;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_PIX_REQ, S_PIX_WAIT, S_PIX_B, S_PIX_G, S_PIX_R,
    S_PAD, S_FLUSH, S_SD_WRITE, S_SD_GAP, S_COMPLITE, S_FAIL
  } state_t;

  state_t      state, state_nxt, ret_state, ret_nxt, after;
  logic [10:0] h, h_nxt, v, v_nxt;
  logic [5:0]  hdr_cnt, hdr_nxt;
  logic [1:0]  pad_cnt, pad_nxt;
  logic [8:0]  byte_ptr, ptr_nxt;
  logic [4:0]  retry, retry_nxt;
  logic [31:0] blk_nxt;
  logic [11:0] pix, pix_nxt;
  logic        emit, row_end;
  logic [7:0]  emit_data;
  logic [7:0]  mem [512];

  logic        unused_bits;
  assign unused_bits = ^{SD_InPut_Data_Addr[31:7], m_out_data[15:12]};

  assign SD_SerialCount     = 32'd0;
  assign Serial_access_read = 1'b0;

  // Header ROM: "BM" followed by thirteen little-endian 32-bit words
  logic [5:0]  hdr_off;
  logic [31:0] hdr_word;
  logic [7:0]  hdr_byte;
  always_comb begin
    hdr_off = hdr_cnt - 6'd2;
    case (hdr_off[5:2])
      4'd0:    hdr_word = 32'(FILESIZE);
      4'd2:    hdr_word = 32'd54;
      4'd3:    hdr_word = 32'd40;
      4'd4:    hdr_word = 32'(IMG_WIDTH);
      4'd5:    hdr_word = 32'(IMG_HEIGHT);
      4'd6:    hdr_word = 32'h0018_0001;
      4'd8:    hdr_word = 32'(IMGSIZE);
      4'd9:    hdr_word = 32'd2835;
      4'd10:   hdr_word = 32'd2835;
      default: hdr_word = 32'd0;
    endcase
    hdr_byte = 8'(hdr_word >> {hdr_off[1:0], 3'b000});
    if (hdr_cnt == 6'd0)      hdr_byte = 8'h42;
    else if (hdr_cnt == 6'd1) hdr_byte = 8'h4D;
  end

  // Next-state and datapath updates
  always_comb begin
    after     = state;
    ret_nxt   = ret_state;
    h_nxt     = h;
    v_nxt     = v;
    hdr_nxt   = hdr_cnt;
    pad_nxt   = pad_cnt;
    ptr_nxt   = byte_ptr;
    retry_nxt = retry;
    blk_nxt   = SD_Addr_Block;
    pix_nxt   = pix;
    emit      = 1'b0;
    emit_data = 8'd0;
    row_end   = 1'b0;

    case (state)
      S_IDLE: begin
        if (BMPSave_En && SD_Init_Complite) begin
          after     = S_HDR;
          blk_nxt   = 32'(START_BLOCK);
          h_nxt     = 11'd0;
          v_nxt     = V_LAST;
          hdr_nxt   = 6'd0;
          pad_nxt   = 2'd0;
          ptr_nxt   = 9'd0;
          retry_nxt = 5'd0;
        end
      end
      S_HDR: begin
        emit      = 1'b1;
        emit_data = hdr_byte;
        hdr_nxt   = hdr_cnt + 6'd1;
        if (hdr_cnt == HDR_LAST) after = S_PIX_REQ;
      end
      S_PIX_REQ: after = S_PIX_WAIT;
      S_PIX_WAIT: begin
        if (m_ready_read) begin
          pix_nxt = m_out_data[11:0];
          after   = S_PIX_B;
        end
      end
      S_PIX_B: begin
        emit      = 1'b1;
        emit_data = {pix[11:8], pix[11:8]};
        after     = S_PIX_G;
      end
      S_PIX_G: begin
        emit      = 1'b1;
        emit_data = {pix[7:4], pix[7:4]};
        after     = S_PIX_R;
      end
      S_PIX_R: begin
        emit      = 1'b1;
        emit_data = {pix[3:0], pix[3:0]};
        if (h != H_LAST) begin
          h_nxt = h + 11'd1;
          after = S_PIX_REQ;
        end else begin
          h_nxt = 11'd0;
          if (PAD_BYTES != 0) after = S_PAD;
          else                row_end = 1'b1;
        end
      end
      S_PAD: begin
        emit = 1'b1;
        if (pad_cnt == PAD_LAST) begin
          pad_nxt = 2'd0;
          row_end = 1'b1;
        end else begin
          pad_nxt = pad_cnt + 2'd1;
        end
      end
      S_FLUSH: begin
        if (byte_ptr == 9'd0) after = S_COMPLITE;
        else                  emit  = 1'b1;
      end
      S_SD_WRITE: begin
        if (SD_Complite) begin
          blk_nxt   = SD_Addr_Block + 32'd1;
          retry_nxt = 5'd0;
          after     = ret_state;
        end else if (SD_Fail) begin
          if (retry == RETRY_MAX) begin
            after = S_FAIL;
          end else begin
            retry_nxt = retry + 5'd1;
            after     = S_SD_GAP;
          end
        end
      end
      S_SD_GAP:   after = S_SD_WRITE;
      S_COMPLITE: after = S_COMPLITE;
      S_FAIL:     after = S_FAIL;
      default:    after = S_IDLE;
    endcase

    // End of a bitmap row: step up one row or finish the pixel data
    if (row_end) begin
      if (v != 11'd0) begin
        v_nxt = v - 11'd1;
        after = S_PIX_REQ;
      end else begin
        after = S_FLUSH;
      end
    end

    state_nxt = after;
    if (emit) begin
      ptr_nxt = byte_ptr + 9'd1;
      if (byte_ptr == PTR_LAST) begin
        state_nxt = S_SD_WRITE;
        ret_nxt   = after;
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      ret_state        <= S_IDLE;
      h                <= 11'd0;
      v                <= 11'd0;
      hdr_cnt          <= 6'd0;
      pad_cnt          <= 2'd0;
      byte_ptr         <= 9'd0;
      retry            <= 5'd0;
      pix              <= 12'd0;
      SD_Addr_Block    <= 32'd0;
      SD_Enable        <= 1'b0;
      SD_Write         <= 1'b0;
      m_valid_read     <= 1'b0;
      m_addr_read      <= 24'd0;
      BMPSave_Complite <= 1'b0;
      BMPSave_Fail     <= 1'b0;
    end else begin
      state            <= state_nxt;
      ret_state        <= ret_nxt;
      h                <= h_nxt;
      v                <= v_nxt;
      hdr_cnt          <= hdr_nxt;
      pad_cnt          <= pad_nxt;
      byte_ptr         <= ptr_nxt;
      retry            <= retry_nxt;
      pix              <= pix_nxt;
      SD_Addr_Block    <= blk_nxt;
      SD_Enable        <= (state_nxt == S_SD_WRITE);
      SD_Write         <= (state_nxt == S_SD_WRITE);
      m_valid_read     <= (state_nxt == S_PIX_WAIT);
      m_addr_read      <= {2'b00, v_nxt, h_nxt};
      BMPSave_Complite <= (state_nxt == S_COMPLITE);
      BMPSave_Fail     <= (state_nxt == S_FAIL);
    end
  end

  // Block buffer byte write port
  always_ff @(posedge clk) begin
    if (emit) mem[byte_ptr] <= emit_data;
  end

  // Word read port for the SD core, first byte in the top lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SD_InPut_Data <= 32'd0;
    end else if (SD_InPut_Data_Valid) begin
      SD_InPut_Data <= {mem[{SD_InPut_Data_Addr[6:0], 2'd0}], mem[{SD_InPut_Data_Addr[6:0], 2'd1}],
                        mem[{SD_InPut_Data_Addr[6:0], 2'd2}], mem[{SD_InPut_Data_Addr[6:0], 2'd3}]};
    end
  end

endmodule

// File: tb/tb_bmp_saver.sv
// Directed bench for bmp_saver: 3x2 image at block 100 with SDRAM and SD card responders.
module tb_bmp_saver;

  localparam int unsigned W  = 3;
  localparam int unsigned H  = 2;
  localparam int unsigned SB = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        BMPSave_En;
  logic        BMPSave_Complite;
  logic        BMPSave_Fail;
  logic        SD_Init_Complite;
  logic [31:0] SD_Addr_Block;
  logic        SD_Enable;
  logic        SD_Write;
  logic        SD_Complite;
  logic        SD_Fail;
  logic [31:0] SD_SerialCount;
  logic        SD_InPut_Data_Valid;
  logic [31:0] SD_InPut_Data_Addr;
  logic [31:0] SD_InPut_Data;
  logic        Serial_access_read;
  logic        m_ready_read;
  logic        m_valid_read;
  logic [23:0] m_addr_read;
  logic [15:0] m_out_data;

  bmp_saver #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .START_BLOCK(SB)) dut (
    .clk(clk), .rst(rst),
    .BMPSave_En(BMPSave_En), .BMPSave_Complite(BMPSave_Complite), .BMPSave_Fail(BMPSave_Fail),
    .SD_Init_Complite(SD_Init_Complite), .SD_Addr_Block(SD_Addr_Block),
    .SD_Enable(SD_Enable), .SD_Write(SD_Write), .SD_Complite(SD_Complite), .SD_Fail(SD_Fail),
    .SD_SerialCount(SD_SerialCount), .SD_InPut_Data_Valid(SD_InPut_Data_Valid),
    .SD_InPut_Data_Addr(SD_InPut_Data_Addr), .SD_InPut_Data(SD_InPut_Data),
    .Serial_access_read(Serial_access_read), .m_ready_read(m_ready_read),
    .m_valid_read(m_valid_read), .m_addr_read(m_addr_read), .m_out_data(m_out_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-computed header for a 3x2 image: FILESIZE 78, IMGSIZE 24
  logic [7:0] hdr_exp [54] = '{
    8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
    8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h18, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0B,
    8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  logic [7:0]  blk [512];
  logic [7:0]  exp_file [512];
  logic [31:0] cmd_addr [64];
  logic [23:0] req_addr [16];
  int          n_cmd;
  int          n_req;
  bit          cmd_bad;
  bit          stall_bad;
  bit          finished;

  // Unique value per pixel; upper nibble is noise the DUT must ignore
  function automatic logic [15:0] pix(input int hh, input int vv);
    if (hh == 0 && vv == 1) return 16'h0ABC;
    return {4'h5, 4'(vv + 1), 4'(hh + 2), 4'(hh + 3 * vv + 4)};
  endfunction

  function automatic logic [127:0] outs();
    return {2'b00, BMPSave_Complite, BMPSave_Fail, SD_Addr_Block, SD_Enable, SD_Write,
            SD_SerialCount, SD_InPut_Data, Serial_access_read, m_valid_read, m_addr_read};
  endfunction

  function automatic int file_diff();
    int d = 0;
    for (int i = 0; i < 512; i++) if (blk[i] !== exp_file[i]) d++;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    BMPSave_En = 1'b0;
    SD_Complite = 1'b0;
    SD_Fail = 1'b0;
    SD_InPut_Data_Valid = 1'b0;
    SD_InPut_Data_Addr = 32'd0;
    m_ready_read = 1'b0;
    m_out_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // stop_mode 1: return at first SDRAM request; 2: return a few words into the first block read
  task automatic run_file(input int fail_n, input int stall_req, input int stop_mode, input int budget);
    int fails_left;
    int rd;
    int stall_cnt;
    logic [23:0] stall_addr;
    fails_left = fail_n;
    rd = -1;
    stall_cnt = 0;
    stall_addr = 24'd0;
    n_cmd = 0;
    n_req = 0;
    cmd_bad = 1'b0;
    stall_bad = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 512; i++) blk[i] = 8'hEE;
    BMPSave_En = 1'b1;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(posedge clk);
      #1;
      if (m_ready_read) begin
        m_ready_read = 1'b0;
      end else if (m_valid_read) begin
        if (stop_mode == 1) return;
        if (n_req == stall_req && stall_cnt < 1000) begin
          if (stall_cnt == 0) stall_addr = m_addr_read;
          else if (m_addr_read !== stall_addr) stall_bad = 1'b1;
          stall_cnt++;
        end else begin
          if (n_req < 16) req_addr[n_req] = m_addr_read;
          n_req++;
          m_out_data = pix(int'(m_addr_read[10:0]), int'(m_addr_read[21:11]));
          m_ready_read = 1'b1;
        end
      end else if (stall_cnt > 0 && stall_cnt < 1000) begin
        stall_bad = 1'b1;
      end

      if (SD_Complite || SD_Fail) begin
        SD_Complite = 1'b0;
        SD_Fail = 1'b0;
      end else if (SD_Enable) begin
        if (rd < 0) begin
          if (n_cmd < 64) cmd_addr[n_cmd] = SD_Addr_Block;
          n_cmd++;
          if (SD_Write !== 1'b1 || SD_SerialCount !== 32'd0) cmd_bad = 1'b1;
          if (fails_left > 0) begin
            fails_left--;
            SD_Fail = 1'b1;
          end else begin
            SD_InPut_Data_Valid = 1'b1;
            SD_InPut_Data_Addr = 32'd0;
            rd = 1;
          end
        end else begin
          for (int b = 0; b < 4; b++) blk[(rd - 1) * 4 + b] = SD_InPut_Data[31 - 8 * b -: 8];
          if (stop_mode == 2 && rd == 5) return;
          if (rd < 128) begin
            SD_InPut_Data_Addr = 32'(rd);
            rd++;
          end else begin
            SD_InPut_Data_Valid = 1'b0;
            SD_Complite = 1'b1;
            rd = -1;
          end
        end
      end
      if (BMPSave_Complite || BMPSave_Fail) finished = 1'b1;
    end
  endtask

  initial begin
    int nz;
    int bad_addr;
    int en_seen;
    logic [15:0] p;

    for (int i = 0; i < 512; i++) exp_file[i] = 8'h00;
    for (int i = 0; i < 54; i++) exp_file[i] = hdr_exp[i];
    for (int r = 0; r < int'(H); r++) begin
      for (int x = 0; x < int'(W); x++) begin
        p = pix(x, int'(H) - 1 - r);
        exp_file[54 + r * 12 + x * 3]     = {p[11:8], p[11:8]};
        exp_file[54 + r * 12 + x * 3 + 1] = {p[7:4], p[7:4]};
        exp_file[54 + r * 12 + x * 3 + 2] = {p[3:0], p[3:0]};
      end
    end

    SD_Init_Complite = 1'b1;
    do_reset();
    check("reset_outs", outs(), 128'd0);

    // Start is gated by SD readiness
    SD_Init_Complite = 1'b0;
    BMPSave_En = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("no_init", {SD_Enable, m_valid_read, BMPSave_Complite}, 3'b000);
    BMPSave_En = 1'b0;
    SD_Init_Complite = 1'b1;

    // Plain save
    run_file(0, -1, 0, 5000);
    check("done", 128'(finished), 128'd1);
    check("flags", {BMPSave_Complite, BMPSave_Fail}, 2'b10);
    check("n_cmd", 128'(n_cmd), 128'd1);
    check("cmd_addr", cmd_addr[0], 128'd100);
    check("cmd_fmt", 128'(cmd_bad), 128'd0);
    check("filesize", {blk[5], blk[4], blk[3], blk[2]}, 128'h4E);
    check("imgsize", {blk[37], blk[36], blk[35], blk[34]}, 128'h18);
    check("pix0", {blk[54], blk[55], blk[56]}, 128'hAABBCC);
    check("row_pad", {blk[63], blk[64], blk[65]}, 128'd0);
    nz = 0;
    for (int i = 78; i < 512; i++) if (blk[i] !== 8'h00) nz++;
    check("tail_zero", 128'(nz), 128'd0);
    check("file", 128'(file_diff()), 128'd0);
    check("addr_after", SD_Addr_Block, 128'd101);
    check("n_req", 128'(n_req), 128'd6);
    check("req_first", req_addr[0], 128'h000800);
    check("req_second", req_addr[1], 128'h000801);
    check("req_row0", req_addr[3], 128'h000000);
    check("req_last", req_addr[5], 128'h000002);
    repeat (20) @(posedge clk);
    #1;
    check("hold_complite", {BMPSave_Complite, SD_Enable, m_valid_read}, 3'b100);

    // Three failures then success: same block retried
    do_reset();
    run_file(3, -1, 0, 5000);
    check("retry_done", {finished, BMPSave_Complite, BMPSave_Fail}, 3'b110);
    check("retry_cmds", 128'(n_cmd), 128'd4);
    bad_addr = 0;
    for (int i = 0; i < 4; i++) if (cmd_addr[i] !== 32'd100) bad_addr++;
    check("retry_addr", 128'(bad_addr), 128'd0);
    check("retry_file", 128'(file_diff()), 128'd0);

    // Thirty-two failures: give up
    do_reset();
    run_file(32, -1, 0, 5000);
    check("fail_flags", {finished, BMPSave_Complite, BMPSave_Fail, SD_Enable}, 4'b1010);
    check("fail_cmds", 128'(n_cmd), 128'd32);
    en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (SD_Enable) en_seen++;
    end
    check("fail_quiet", 128'(en_seen), 128'd0);

    // Long SDRAM stall mid-row
    do_reset();
    run_file(0, 2, 0, 5000);
    check("stall_done", {finished, BMPSave_Complite}, 2'b11);
    check("stall_stable", 128'(stall_bad), 128'd0);
    check("stall_addr", req_addr[2], 128'h000802);
    check("stall_file", 128'(file_diff()), 128'd0);

    // Reset while waiting for a pixel, then a clean restart
    do_reset();
    run_file(0, -1, 1, 5000);
    check("at_pixwait", 128'(m_valid_read), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_pixwait", outs(), 128'd0);
    do_reset();
    run_file(0, -1, 0, 5000);
    check("restart1", {finished, BMPSave_Complite}, 2'b11);
    check("restart1_addr", cmd_addr[0], 128'd100);
    check("restart1_file", 128'(file_diff()), 128'd0);

    // Reset during a block write, then a clean restart
    do_reset();
    run_file(0, -1, 2, 5000);
    check("at_sdwrite", 128'(SD_Enable), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_sdwrite", outs(), 128'd0);
    do_reset();
    run_file(0, -1, 0, 5000);
    check("restart2", {finished, BMPSave_Complite}, 2'b11);
    check("restart2_addr", cmd_addr[0], 128'd100);
    check("restart2_file", 128'(file_diff()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
